cell_plotter: RTL and testbench
===============================

Name: cell_plotter

Overview:
- Consumer end of the cursor-to-pixel interface. Takes one cell request: base X/Y, colour and draw_full. Rasterises it into single-pixel writes for the VGA adapter (x, y, colour, plot).
- Draws either a filled box or an outline box at the cell origin. Also provides a full-screen clear.
- Sits between the cell translator and the VGA adapter. It decouples cursor updates from pixel timing with a start/busy/done handshake.

Parameters:
BOX_W, 8, cell box width in pixels (fits the 11-pixel column pitch)
BOX_H, 6, cell box height in pixels (fits the 8-pixel row pitch)
SCREEN_W, 160, visible width; pixels with x >= SCREEN_W are suppressed
SCREEN_H, 120, visible height; pixels with y >= SCREEN_H are suppressed
CLEAR_COLOUR, 3'b000, background colour for the clear pass and outline interiors

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request a cell draw; sampled only in IDLE
clear_req  in  1  request a full-screen clear; sampled only in IDLE; wins over start
x_in  in  8  cell origin X
y_in  in  8  cell origin Y
colour_in  in  3  cell colour
draw_full  in  1  1 = filled box, 0 = outline box
vga_x  out  8  pixel X to the VGA adapter
vga_y  out  7  pixel Y to the VGA adapter
vga_colour  out  3  pixel colour
plot  out  1  write strobe, one pixel per cycle
busy  out  1  high in DRAW, CLEAR and FINISH
done  out  1  one-cycle pulse in FINISH

Behaviour:
- All outputs are registered.
- Reset values: vga_x=0, vga_y=0, vga_colour=0, plot=0, busy=0, done=0. State is IDLE and all counters are 0.
- Reset mid-operation aborts immediately. No further plot pulses occur and no done pulse is produced.
- FSM states: IDLE, DRAW, CLEAR, FINISH.

IDLE:
- If clear_req=1, go to CLEAR.
- Else if start=1, latch x_in, y_in, colour_in and draw_full, then go to DRAW.
- Inputs are not latched on other cycles.

DRAW:
- Counters dx (0..BOX_W-1, inner) and dy (0..BOX_H-1, outer) step once per cycle in row-major order.
- Pixel address: px = base_x + dx and py = base_y + dy, computed in 9 bits with no wrap.
- Border pixel: dx==0, dx==BOX_W-1, dy==0 or dy==BOX_H-1.
- Pixel colour:
  - Filled box: latched colour for every pixel.
  - Outline box: latched colour on border pixels, CLEAR_COLOUR on interior pixels. An outline therefore overwrites a previous filled box.
- plot=1 only if px < SCREEN_W and py < SCREEN_H. Otherwise plot=0, but the counters still advance.
- Fixed duration of BOX_W*BOX_H cycles, regardless of clipping.
- After the last pixel, go to FINISH.

CLEAR:
- Sweeps x 0..SCREEN_W-1 (inner) and y 0..SCREEN_H-1 (outer).
- Every pixel is written with plot=1 and colour CLEAR_COLOUR.
- Takes SCREEN_W*SCREEN_H cycles, then goes to FINISH.

FINISH:
- Lasts one cycle with plot=0, done=1, busy=1.
- Then returns to IDLE.

Timing:
- A request sampled at cycle 0 produces the first plot at cycle 1.
- For a DRAW, the last plot is at cycle BOX_W*BOX_H and done is at cycle BOX_W*BOX_H+1.
- busy falls at cycle BOX_W*BOX_H+2, the first cycle a new request can be accepted.

Handshake and output rules:
- start and clear_req are ignored while busy=1. There is no queuing.
- The requester holds inputs valid only in the start cycle.
- vga_x and vga_y take the low bits of the in-range px and py.
- When plot=0, vga_x, vga_y and vga_colour hold their previous values.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE, DRAW, CLEAR, FINISH);
  - colour constants: COLOUR_RED=3'b100, COLOUR_WHITE=3'b111, COLOUR_BLACK=3'b000;
  - cell geometry constants: column pitch 11, row pitch 8, origin 28/30. The translator and plotter share these.
- One natural sub-module: raster_counter, a parameterised 2-D nested counter with enable and a last-pixel flag.
  - It is instantiated twice: BOX_W×BOX_H for DRAW and SCREEN_W×SCREEN_H for CLEAR.
  - Alternatively, one instance with a runtime-selected limit.

Test Plan:
- Filled draw: start with x_in=28, y_in=30, colour_in=3'b100, draw_full=1.
  - Expect 48 plots covering x 28..35, y 30..35, all colour 100.
  - Order: (28,30),(29,30)…(35,35).
  - done at cycle 49; busy low at cycle 50.
- Outline draw: start with x_in=39, y_in=38, colour_in=3'b111, draw_full=0.
  - Expect 48 plots: 24 border pixels with colour 111 and 24 interior pixels (x 40..45, y 39..42) with colour 000.
- Clipping: start with x_in=156, y_in=116, draw_full=1.
  - Expect plots only for x 156..159 and y 116..119, 16 plots in total.
  - done still at cycle 49.
- Busy/priority:
  - A second start at cycle 10 of a draw is ignored; exactly 48 plots result.
  - clear_req and start together in IDLE enter CLEAR, giving 19200 plots of colour 000 and then done.
- Reset mid-draw: assert reset at cycle 20 of a draw.
  - All outputs go to 0 asynchronously, with no done pulse.
  - After reset is released, a new start draws a complete box.

Source files
------------

// File: rtl/cell_plotter_pkg.sv
// Purpose: shared FSM encoding, colour constants and cell geometry for the cursor-to-pixel path.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package cell_plotter_pkg;

    // Plotter sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAW   = 2'd1,
        ST_CLEAR  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    // 3-bit RGB colours used by the translator and the plotter.
    localparam logic [2:0] COLOUR_RED   = 3'b100;
    localparam logic [2:0] COLOUR_WHITE = 3'b111;
    localparam logic [2:0] COLOUR_BLACK = 3'b000;

    // Cell grid geometry: the box drawn per cell sits inside one pitch step.
    localparam int CELL_PITCH_X  = 11;
    localparam int CELL_PITCH_Y  = 8;
    localparam int CELL_ORIGIN_X = 28;
    localparam int CELL_ORIGIN_Y = 30;

    // Pixel X of the top-left corner of grid column col.
    function automatic logic [7:0] cell_base_x(input logic [3:0] col);
        return 8'(CELL_ORIGIN_X + CELL_PITCH_X * int'(col));
    endfunction

    // Pixel Y of the top-left corner of grid row row.
    function automatic logic [7:0] cell_base_y(input logic [3:0] row);
        return 8'(CELL_ORIGIN_Y + CELL_PITCH_Y * int'(row));
    endfunction

    // Counter width able to hold 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cell_plotter_raster_counter.sv
// Purpose: 2-D nested counter sweeping (cx, cy) in row-major order, cx innermost.
// Latency: counts advance on the edge after en; last is combinational from the count.
// Backpressure: none; en stalls the sweep, clr returns it to the origin.
module raster_counter
    import cell_plotter_pkg::*;
#(
    parameter int W  = 8,
    parameter int H  = 6,
    parameter int XW = cnt_width(W),
    parameter int YW = cnt_width(H)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    output logic [XW-1:0] cx,
    output logic [YW-1:0] cy,
    output logic          last
);

    localparam logic [XW-1:0] X_LAST = XW'(W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(H - 1);

    logic x_end;
    logic y_end;

    assign x_end = (cx == X_LAST);
    assign y_end = (cy == Y_LAST);
    assign last  = x_end && y_end;

    // Step the inner coordinate, carry into the outer one, wrap to the origin after the last point.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cx <= '0;
            cy <= '0;
        end else if (clr) begin
            cx <= '0;
            cy <= '0;
        end else if (en) begin
            if (x_end) begin
                cx <= '0;
                cy <= y_end ? '0 : cy + 1'b1;
            end else begin
                cx <= cx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cell_plotter.sv
// Purpose: rasterise one cell request (filled or outline box) or a full-screen clear into VGA pixel writes.
// Latency: first plot one cycle after the accepting edge; a box takes BOX_W*BOX_H plots, then done, then busy drops.
// Backpressure: requests are only sampled while idle; anything presented while busy is dropped, never queued.
module cell_plotter
    import cell_plotter_pkg::*;
#(
    parameter int         BOX_W        = 8,
    parameter int         BOX_H        = 6,
    parameter int         SCREEN_W     = 160,
    parameter int         SCREEN_H     = 120,
    parameter logic [2:0] CLEAR_COLOUR = COLOUR_BLACK
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       clear_req,
    input  logic [7:0] x_in,
    input  logic [7:0] y_in,
    input  logic [2:0] colour_in,
    input  logic       draw_full,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam int DXW = cnt_width(BOX_W);
    localparam int DYW = cnt_width(BOX_H);
    localparam int SXW = cnt_width(SCREEN_W);
    localparam int SYW = cnt_width(SCREEN_H);

    localparam logic [DXW-1:0] DX_LAST = DXW'(BOX_W - 1);
    localparam logic [DYW-1:0] DY_LAST = DYW'(BOX_H - 1);

    state_t state;

    // Cell request captured on the accepting edge; the requester only holds it for that cycle.
    logic [7:0] base_x;
    logic [7:0] base_y;
    logic [2:0] cell_colour;
    logic       cell_full;

    logic [DXW-1:0] dx;
    logic [DYW-1:0] dy;
    logic           box_last;
    logic [SXW-1:0] sx;
    logic [SYW-1:0] sy;
    logic           screen_last;

    logic       box_clr;
    logic       box_en;
    logic       screen_en;
    logic [8:0] px;
    logic [8:0] py;
    logic       in_range;
    logic       border;
    logic [2:0] pixel_colour;

    // Both sweeps sit at their origin whenever the FSM is idle, so a new pass always starts at (0,0).
    assign box_clr   = (state == ST_IDLE);
    assign box_en    = (state == ST_DRAW);
    assign screen_en = (state == ST_CLEAR);

    raster_counter #(
        .W (BOX_W),
        .H (BOX_H),
        .XW(DXW),
        .YW(DYW)
    ) u_box_counter (
        .clock(clock),
        .reset(reset),
        .clr  (box_clr),
        .en   (box_en),
        .cx   (dx),
        .cy   (dy),
        .last (box_last)
    );

    raster_counter #(
        .W (SCREEN_W),
        .H (SCREEN_H),
        .XW(SXW),
        .YW(SYW)
    ) u_screen_counter (
        .clock(clock),
        .reset(reset),
        .clr  (box_clr),
        .en   (screen_en),
        .cx   (sx),
        .cy   (sy),
        .last (screen_last)
    );

    // Pixel address is formed one bit wider than the screen so boxes near the edge clip instead of wrapping.
    assign px       = {1'b0, base_x} + 9'(dx);
    assign py       = {1'b0, base_y} + 9'(dy);
    assign in_range = (px < 9'(SCREEN_W)) && (py < 9'(SCREEN_H));

    // Outline boxes paint their interior with the background so they fully replace an earlier filled box.
    assign border       = (dx == '0) || (dx == DX_LAST) || (dy == '0) || (dy == DY_LAST);
    assign pixel_colour = (cell_full || border) ? cell_colour : CLEAR_COLOUR;

    // Sequencer with registered pixel outputs; pixel address/colour hold whenever plot is low.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            base_x      <= '0;
            base_y      <= '0;
            cell_colour <= '0;
            cell_full   <= 1'b0;
            vga_x       <= '0;
            vga_y       <= '0;
            vga_colour  <= '0;
            plot        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            plot <= 1'b0;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    busy <= 1'b0;
                    if (clear_req) begin
                        state <= ST_CLEAR;
                        busy  <= 1'b1;
                    end else if (start) begin
                        base_x      <= x_in;
                        base_y      <= y_in;
                        cell_colour <= colour_in;
                        cell_full   <= draw_full;
                        state       <= ST_DRAW;
                        busy        <= 1'b1;
                    end
                end
                ST_DRAW: begin
                    // Off-screen pixels still consume their cycle so a draw has a fixed duration.
                    if (in_range) begin
                        plot       <= 1'b1;
                        vga_x      <= px[7:0];
                        vga_y      <= py[6:0];
                        vga_colour <= pixel_colour;
                    end
                    if (box_last) begin
                        state <= ST_FINISH;
                    end
                end
                ST_CLEAR: begin
                    plot       <= 1'b1;
                    vga_x      <= 8'(sx);
                    vga_y      <= 7'(sy);
                    vga_colour <= CLEAR_COLOUR;
                    if (screen_last) begin
                        state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    // busy stays high through the done cycle and drops on the next idle edge.
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cell_plotter.sv
// Purpose: directed self-checking bench for cell_plotter (filled, outline, clipped, busy-ignore, clear, reset abort).
// Latency: samples every cycle on the falling edge and compares against an in-bench pixel model.
// Backpressure: drives requests only when the design should be idle, plus deliberate pokes while busy.
module tb_cell_plotter;

    localparam int BW = 8;
    localparam int BH = 6;
    localparam int SW = 160;
    localparam int SH = 120;

    logic       clock     = 1'b0;
    logic       reset     = 1'b1;
    logic       start     = 1'b0;
    logic       clear_req = 1'b0;
    logic [7:0] x_in      = 8'd0;
    logic [7:0] y_in      = 8'd0;
    logic [2:0] colour_in = 3'd0;
    logic       draw_full = 1'b0;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;

    // Model of the held pixel outputs.
    logic [7:0] m_x;
    logic [6:0] m_y;
    logic [2:0] m_c;

    cell_plotter dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .clear_req (clear_req),
        .x_in      (x_in),
        .y_in      (y_in),
        .colour_in (colour_in),
        .draw_full (draw_full),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .vga_colour(vga_colour),
        .plot      (plot),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    endtask

    // Issue one request, follow it cycle by cycle through done and the busy drop, then check the totals.
    task automatic run_op(input string tag, input bit is_clear,
                          input logic [7:0] x, input logic [7:0] y, input logic [2:0] col, input logic full,
                          input int poke, input int exp_plots, input int exp_colcnt,
                          input int fx, input int fy, input int lx, input int ly);
        int n, plots, colcnt, pix_bad, ctrl_bad, done_cyc, fall_cyc, ffx, ffy, llx, lly;
        n = is_clear ? SW * SH : BW * BH;
        plots = 0; colcnt = 0; pix_bad = 0; ctrl_bad = 0;
        done_cyc = -1; fall_cyc = -1; ffx = -1; ffy = -1; llx = -1; lly = -1;
        @(negedge clock);
        clear_req = is_clear;
        start     = 1'b1;
        x_in      = x;
        y_in      = y;
        colour_in = is_clear ? ~col : col;
        draw_full = full;
        for (int k = 0; k <= n + 2; k++) begin
            bit ep;
            int idx, dx, dy, px, py;
            @(negedge clock);
            ep = 1'b0;
            if (k >= 1 && k <= n) begin
                idx = k - 1;
                if (is_clear) begin
                    px = idx % SW;
                    py = idx / SW;
                    ep = 1'b1;
                    m_c = 3'b000;
                end else begin
                    dx = idx % BW;
                    dy = idx / BW;
                    px = int'(x) + dx;
                    py = int'(y) + dy;
                    ep = (px < SW) && (py < SH);
                    if (ep) m_c = (full || dx == 0 || dx == BW - 1 || dy == 0 || dy == BH - 1) ? col : 3'b000;
                end
                if (ep) begin
                    m_x = 8'(px);
                    m_y = 7'(py);
                end
            end
            if (plot !== ep || vga_x !== m_x || vga_y !== m_y || vga_colour !== m_c) pix_bad++;
            if (plot === 1'b1) begin
                plots++;
                if (vga_colour === col) colcnt++;
                if (ffx < 0) begin
                    ffx = int'(vga_x);
                    ffy = int'(vga_y);
                end
                llx = int'(vga_x);
                lly = int'(vga_y);
            end
            if (done === 1'b1 && done_cyc < 0) done_cyc = k;
            if (busy !== (k <= n + 1) || done !== (k == n + 1)) ctrl_bad++;
            if (k >= 1 && busy === 1'b0 && fall_cyc < 0) fall_cyc = k;
            start     = (k == poke);
            clear_req = 1'b0;
            x_in      = ~x;
            y_in      = ~y;
            colour_in = ~col;
            draw_full = ~full;
        end
        check({tag, ".plots"},     plots,    exp_plots);
        check({tag, ".colour_n"},  colcnt,   exp_colcnt);
        check({tag, ".pixel_err"}, pix_bad,  0);
        check({tag, ".ctrl_err"},  ctrl_bad, 0);
        check({tag, ".done_cyc"},  done_cyc, n + 1);
        check({tag, ".busy_fall"}, fall_cyc, n + 2);
        check({tag, ".first_x"},   ffx,      fx);
        check({tag, ".first_y"},   ffy,      fy);
        check({tag, ".last_x"},    llx,      lx);
        check({tag, ".last_y"},    lly,      ly);
    endtask

    initial begin
        int quiet;
        m_x = '0;
        m_y = '0;
        m_c = '0;

        // Reset state.
        repeat (2) @(negedge clock);
        check("rst0.plot",   plot,       0);
        check("rst0.busy",   busy,       0);
        check("rst0.done",   done,       0);
        check("rst0.x",      vga_x,      0);
        check("rst0.y",      vga_y,      0);
        check("rst0.colour", vga_colour, 0);
        reset = 1'b0;

        // Filled box at the first cell origin.
        run_op("fill", 1'b0, 8'd28, 8'd30, 3'b100, 1'b1, -1, 48, 48, 28, 30, 35, 35);
        // Outline box: 24 border pixels in white, 24 interior pixels in background.
        run_op("outline", 1'b0, 8'd39, 8'd38, 3'b111, 1'b0, -1, 48, 24, 39, 38, 46, 43);
        // Box hanging off the bottom-right corner: only a 4x4 corner is visible.
        run_op("clip", 1'b0, 8'd156, 8'd116, 3'b010, 1'b1, -1, 16, 16, 156, 116, 159, 119);
        // Second start while busy must be ignored.
        run_op("poke", 1'b0, 8'd100, 8'd80, 3'b011, 1'b1, 10, 48, 48, 100, 80, 107, 85);
        // clear_req together with start: clear wins and sweeps the whole screen.
        run_op("clear", 1'b1, 8'd50, 8'd40, 3'b000, 1'b1, -1, 19200, 19200, 0, 0, 159, 119);

        // Reset asserted in the middle of a draw.
        @(negedge clock);
        start = 1'b1; x_in = 8'd60; y_in = 8'd50; colour_in = 3'b001; draw_full = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (20) @(negedge clock);
        check("rstmid.pre_plot", plot, 1);
        #2 reset = 1'b1;
        #1;
        check("rstmid.plot",   plot,       0);
        check("rstmid.busy",   busy,       0);
        check("rstmid.done",   done,       0);
        check("rstmid.x",      vga_x,      0);
        check("rstmid.y",      vga_y,      0);
        check("rstmid.colour", vga_colour, 0);
        m_x = '0;
        m_y = '0;
        m_c = '0;
        quiet = 0;
        repeat (3) begin
            @(negedge clock);
            if (plot !== 1'b0 || done !== 1'b0) quiet++;
        end
        reset = 1'b0;
        repeat (60) begin
            @(negedge clock);
            if (plot !== 1'b0 || done !== 1'b0 || busy !== 1'b0) quiet++;
        end
        check("rstmid.quiet", quiet, 0);

        // A fresh request after the aborted one draws a complete box.
        run_op("redraw", 1'b0, 8'd2, 8'd3, 3'b101, 1'b0, -1, 48, 24, 2, 3, 9, 8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
